regfile_wb_arbiter: RTL and testbench

- Writer side of the core's 32x32 register file: merges writeback traffic onto the single write port (wen/wraddr/wrdata).
- Two sources:
  - Port A: single-cycle ALU results. Cannot stall; always has priority.
  - Port B: long-latency LSU/MDU results. Valid/ready handshake, buffered in a small FIFO.
- Keeps a pending-write scoreboard so decode can stall on registers with outstanding long-latency writes.

---
 rtl/regfile_wb_arbiter_pkg.sv | 31 +++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 119 +++++++++++
 rtl/regfile_wb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared constants for the register-file writeback arbiter.
//   - Default data width, register-address width and FIFO depth.
//   - REG_ZERO: the hard-wired zero register, which is never written.
//   - Layout of a port-B FIFO entry, packed as {live, rd, data}:
//       data : [XLEN-1:0]
//       rd   : [XLEN+REG_AW-1:XLEN]
//       live : [XLEN+REG_AW]
//   Optional statistics counters (macro WB_STATS_EN) are STAT_W bits wide.
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int WB_XLEN       = 32;
    localparam int WB_REG_AW     = 5;
    localparam int WB_FIFO_DEPTH = 2;
    localparam int STAT_W        = 32;

    localparam logic [WB_REG_AW-1:0] REG_ZERO = 5'd0;

    // Total width of one packed {live, rd, data} entry.
    function automatic int ent_w(input int xlen, input int aw);
        return 1 + aw + xlen;
    endfunction

    // Bit position of the live flag; rd sits directly below it.
    function automatic int ent_live_bit(input int xlen, input int aw);
        return xlen + aw;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   Circular buffer of port-B writeback results with a per-entry live bit.
//   A kill (kill_en, kill_rd) clears the live bit of every live entry whose
//   rd matches, and stores a same-cycle push to that rd as dead.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     push, push_rd/data   store an entry at the tail (caller checks full)
//     pop                  drop the head entry (caller checks empty)
//     kill_en, kill_rd     younger write to kill_rd is happening this cycle
//     full, empty          occupancy flags from the explicit count register
//     head_live/rd/data    current head entry
//     kill_cnt             number of entries killed this cycle (incl. push)
// ---------------------------------------------------------------------------
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN   = WB_XLEN,
    parameter int REG_AW = WB_REG_AW,
    parameter int DEPTH  = WB_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [REG_AW-1:0]         push_rd,
    input  logic [XLEN-1:0]           push_data,
    input  logic                      pop,
    input  logic                      kill_en,
    input  logic [REG_AW-1:0]         kill_rd,
    output logic                      full,
    output logic                      empty,
    output logic                      head_live,
    output logic [REG_AW-1:0]         head_rd,
    output logic [XLEN-1:0]           head_data,
    output logic [$clog2(DEPTH)+1:0]  kill_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int KC_W   = PTR_W + 2;
    localparam int ENT_W  = ent_w(XLEN, REG_AW);
    localparam int LIVE_B = ent_live_bit(XLEN, REG_AW);

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;
    logic [DEPTH-1:0] hit_s;
    logic             push_live_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign head_live = mem_r[rptr_r][LIVE_B];
    assign head_rd   = mem_r[rptr_r][LIVE_B-1 -: REG_AW];
    assign head_data = mem_r[rptr_r][XLEN-1:0];

    // Kill matching: live entries with the killed rd, and the incoming push.
    // Live bits are cleared on pop and reset, so live implies occupied.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && mem_r[i][LIVE_B] && (mem_r[i][LIVE_B-1 -: REG_AW] == kill_rd)) begin
                hit_s[i] = 1'b1;
            end else begin
                hit_s[i] = 1'b0;
            end
        end
        if (kill_en && (push_rd == kill_rd)) begin
            push_live_s = 1'b0;
        end else begin
            push_live_s = 1'b1;
        end
    end

    // Number of entries killed this cycle, a pushed-dead entry included.
    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_cnt = kill_cnt + KC_W'(hit_s[i]);
        end
        if (push && !push_live_s) begin
            kill_cnt = kill_cnt + KC_W'(1);
        end else begin
            kill_cnt = kill_cnt;
        end
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit_s[i]) begin
                    mem_r[i][LIVE_B] <= 1'b0;
                end
            end
            if (pop) begin
                mem_r[rptr_r][LIVE_B] <= 1'b0;
                rptr_r                <= rptr_r + PTR_W'(1);
            end
            if (push) begin
                mem_r[wptr_r] <= {push_live_s, push_rd, push_data};
                wptr_r        <= wptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Writer side of the register file. Merges single-cycle ALU results
//   (port A, always wins, cannot stall) and buffered long-latency results
//   (port B, valid/ready into wb_fifo) onto one registered write port, and
//   keeps a pending-write scoreboard for decode.
//   An A write to rd X is younger than every port-B result to X (including a
//   same-cycle push), so those B results are killed rather than written.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     a_valid, a_rd, a_data        ALU result
//     b_valid, b_ready, b_rd, b_data  long-latency result handshake
//     issue_valid, issue_rd        long-latency op issued by decode
//     busy                         bit r set while a write to xr is pending
//     wen, wraddr, wrdata          registered register-file write port
//   Optional (macro WB_STATS_EN): stat_b_stall, stat_kill saturating counters.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int REG_AW     = WB_REG_AW,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_valid,
    input  logic [REG_AW-1:0]       a_rd,
    input  logic [XLEN-1:0]         a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [REG_AW-1:0]       b_rd,
    input  logic [XLEN-1:0]         b_data,
    input  logic                    issue_valid,
    input  logic [REG_AW-1:0]       issue_rd,
    output logic [(1<<REG_AW)-1:0]  busy,
    output logic                    wen,
    output logic [REG_AW-1:0]       wraddr,
    output logic [XLEN-1:0]         wrdata
`ifdef WB_STATS_EN
    ,
    output logic [STAT_W-1:0]       stat_b_stall,
    output logic [STAT_W-1:0]       stat_kill
`endif
);

    localparam int NREGS = 1 << REG_AW;
    localparam int KC_W  = $clog2(FIFO_DEPTH) + 2;
    localparam logic [REG_AW-1:0] RD_ZERO = REG_AW'(REG_ZERO);

    logic              a_sel_s;
    logic              pop_s;
    logic              push_s;
    logic              b_ready_s;
    logic              wr_en_s;
    logic [REG_AW-1:0] wr_addr_s;
    logic [XLEN-1:0]   wr_data_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              head_live_s;
    logic [REG_AW-1:0] head_rd_s;
    logic [XLEN-1:0]   head_data_s;
    logic [KC_W-1:0]   kill_cnt_s;
    logic [NREGS-1:0]  set_mask_s;
    logic [NREGS-1:0]  clr_mask_s;
    logic [NREGS-1:0]  busy_nxt_s;

    logic              wen_r;
    logic [REG_AW-1:0] wraddr_r;
    logic [XLEN-1:0]   wrdata_r;
    logic [NREGS-1:0]  busy_r;

    // b_rd==0 is accepted by the handshake but never stored.
    assign b_ready_s = !rst && !fifo_full_s;
    assign push_s    = b_valid && b_ready_s && (b_rd != RD_ZERO);

    assign b_ready = b_ready_s;
    assign busy    = busy_r;
    assign wen     = wen_r;
    assign wraddr  = wraddr_r;
    assign wrdata  = wrdata_r;

    wb_fifo #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_rd   (b_rd),
        .push_data (b_data),
        .pop       (pop_s),
        .kill_en   (a_sel_s),
        .kill_rd   (a_rd),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head_live (head_live_s),
        .head_rd   (head_rd_s),
        .head_data (head_data_s),
        .kill_cnt  (kill_cnt_s)
    );

    // Write-port selection: A first, else drain the FIFO head (dead heads pop silently).
    always_comb begin
        a_sel_s = a_valid && (a_rd != RD_ZERO);
        if (a_sel_s) begin
            pop_s     = 1'b0;
            wr_en_s   = 1'b1;
            wr_addr_s = a_rd;
            wr_data_s = a_data;
        end else if (!fifo_empty_s) begin
            pop_s     = 1'b1;
            wr_en_s   = head_live_s;
            wr_addr_s = head_rd_s;
            wr_data_s = head_data_s;
        end else begin
            pop_s     = 1'b0;
            wr_en_s   = 1'b0;
            wr_addr_s = RD_ZERO;
            wr_data_s = '0;
        end
    end

    // Scoreboard update: clear on live B write or kill, then set (set wins), x0 forced clear.
    always_comb begin
        set_mask_s = (issue_valid && (issue_rd != RD_ZERO)) ? (NREGS'(1) << issue_rd) : '0;
        clr_mask_s = '0;
        if (pop_s && head_live_s) begin
            clr_mask_s = clr_mask_s | (NREGS'(1) << head_rd_s);
        end else begin
            clr_mask_s = clr_mask_s;
        end
        if (kill_cnt_s != KC_W'(0)) begin
            clr_mask_s = clr_mask_s | (NREGS'(1) << a_rd);
        end else begin
            clr_mask_s = clr_mask_s;
        end
        busy_nxt_s    = (busy_r & ~clr_mask_s) | set_mask_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Registered write port and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_r    <= 1'b0;
            wraddr_r <= RD_ZERO;
            wrdata_r <= '0;
            busy_r   <= '0;
        end else begin
            wen_r    <= wr_en_s;
            wraddr_r <= wr_addr_s;
            wrdata_r <= wr_data_s;
            busy_r   <= busy_nxt_s;
        end
    end

`ifdef WB_STATS_EN
    logic [STAT_W-1:0] stat_b_stall_r;
    logic [STAT_W-1:0] stat_kill_r;
    logic [STAT_W:0]   kill_sum_s;

    assign stat_b_stall = stat_b_stall_r;
    assign stat_kill    = stat_kill_r;
    assign kill_sum_s   = {1'b0, stat_kill_r} + (STAT_W+1)'(kill_cnt_s);

    // Saturating stall and kill counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_b_stall_r <= '0;
            stat_kill_r    <= '0;
        end else begin
            if (b_valid && !b_ready_s && (stat_b_stall_r != '1)) begin
                stat_b_stall_r <= stat_b_stall_r + STAT_W'(1);
            end else begin
                stat_b_stall_r <= stat_b_stall_r;
            end
            if (kill_sum_s[STAT_W]) begin
                stat_kill_r <= '1;
            end else begin
                stat_kill_r <= kill_sum_s[STAT_W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed vector table for the writeback arbiter corner cases, followed by
//   randomized traffic checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        wen;
    logic [4:0]  wraddr;
    logic [31:0] wrdata;
`ifdef WB_STATS_EN
    logic [31:0] stat_b_stall;
    logic [31:0] stat_kill;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .XLEN       (32),
        .REG_AW     (5),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .busy         (busy),
        .wen          (wen),
        .wraddr       (wraddr),
        .wrdata       (wrdata)
`ifdef WB_STATS_EN
        ,
        .stat_b_stall (stat_b_stall),
        .stat_kill    (stat_kill)
`endif
    );

    // One cycle of stimulus plus expectations: b_ready is expected during the
    // cycle, wen/wraddr/wrdata/busy after the following clock edge.
    typedef struct {
        int rst;
        int av;  int ard; int ad;
        int bv;  int brd; int bd;
        int iv;  int ird;
        int e_rdy;
        int e_wen; int e_addr; int e_data;
        int e_busy;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        live;
    } ment_t;

    localparam int NVEC  = 26;
    localparam int DEPTH = 2;

    vec_t  tab [NVEC];
    ment_t mq [$];
    logic [31:0] m_busy;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: program-order queue of B results; an A write kills
    // every queued or arriving B result to the same register.
    task automatic model_step(input vec_t v);
        ment_t e;
        bit    asel;
        bit    room;
        if (v.rst != 0) begin
            mq.delete();
            m_busy = '0;
            m_wen  = 1'b0;
        end else begin
            room  = (mq.size() < DEPTH);
            m_wen = 1'b0;
            asel  = (v.av != 0) && (v.ard != 0);
            if (asel) begin
                m_wen  = 1'b1;
                m_addr = 5'(v.ard);
                m_data = 32'(v.ad);
                foreach (mq[i]) begin
                    if (mq[i].live && (mq[i].rd == 5'(v.ard))) begin
                        mq[i].live = 1'b0;
                        m_busy[v.ard] = 1'b0;
                    end
                end
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live) begin
                    m_wen  = 1'b1;
                    m_addr = e.rd;
                    m_data = e.data;
                    m_busy[e.rd] = 1'b0;
                end
            end
            if ((v.bv != 0) && room && (v.brd != 0)) begin
                e.rd   = 5'(v.brd);
                e.data = 32'(v.bd);
                e.live = !(asel && (v.brd == v.ard));
                if (!e.live) m_busy[v.brd] = 1'b0;
                mq.push_back(e);
            end
            if ((v.iv != 0) && (v.ird != 0)) m_busy[v.ird] = 1'b1;
        end
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tab, input int idx);
        logic exp_rdy;
        string tag;
        tag         = use_tab ? $sformatf("vec%0d", idx) : $sformatf("rnd%0d", idx);
        rst         = (v.rst != 0);
        a_valid     = (v.av != 0);
        a_rd        = 5'(v.ard);
        a_data      = 32'(v.ad);
        b_valid     = (v.bv != 0);
        b_rd        = 5'(v.brd);
        b_data      = 32'(v.bd);
        issue_valid = (v.iv != 0);
        issue_rd    = 5'(v.ird);
        #1;
        exp_rdy = use_tab ? (v.e_rdy != 0) : ((v.rst == 0) && (mq.size() < DEPTH));
        chk({tag, " b_ready"}, 32'(b_ready), 32'(exp_rdy));
        model_step(v);
        @(posedge clk);
        #1;
        if (use_tab) begin
            chk({tag, " wen"}, 32'(wen), 32'(v.e_wen));
            if (v.e_wen != 0) begin
                chk({tag, " wraddr"}, 32'(wraddr), 32'(v.e_addr));
                chk({tag, " wrdata"}, wrdata, 32'(v.e_data));
            end
            chk({tag, " busy"}, busy, 32'(v.e_busy));
        end else begin
            chk({tag, " wen"}, 32'(wen), 32'(m_wen));
            if (m_wen) begin
                chk({tag, " wraddr"}, 32'(wraddr), 32'(m_addr));
                chk({tag, " wrdata"}, wrdata, m_data);
            end
            chk({tag, " busy"}, busy, m_busy);
        end
    endtask

    initial begin
        vec_t v;
        //          rst av ard ad      bv brd bd     iv ird rdy wen adr data    busy
        tab[ 0] = '{1,  0, 0,  0,      0, 0,  0,     0, 0,  0,  0,  0,  0,      0};
        // A priority over a queued B entry
        tab[ 1] = '{0,  0, 0,  0,      1, 7,  'h22,  1, 7,  1,  0,  0,  0,      'h80};
        tab[ 2] = '{0,  1, 5,  'h11,   0, 0,  0,     0, 0,  1,  1,  5,  'h11,   'h80};
        tab[ 3] = '{0,  0, 0,  0,      0, 0,  0,     0, 0,  1,  1,  7,  'h22,   0};
        tab[ 4] = '{0,  0, 0,  0,      0, 0,  0,     0, 0,  1,  0,  0,  0,      0};
        // FIFO fills while A is busy, then drains in order
        tab[ 5] = '{0,  1, 1,  'h101,  1, 10, 'hA0,  0, 0,  1,  1,  1,  'h101,  0};
        tab[ 6] = '{0,  1, 2,  'h102,  1, 11, 'hB0,  0, 0,  1,  1,  2,  'h102,  0};
        tab[ 7] = '{0,  1, 3,  'h103,  1, 12, 'hC0,  0, 0,  0,  1,  3,  'h103,  0};
        tab[ 8] = '{0,  0, 0,  0,      1, 12, 'hC0,  0, 0,  0,  1,  10, 'hA0,   0};
        tab[ 9] = '{0,  0, 0,  0,      1, 12, 'hC0,  0, 0,  1,  1,  11, 'hB0,   0};
        tab[10] = '{0,  0, 0,  0,      0, 0,  0,     0, 0,  1,  1,  12, 'hC0,   0};
        // WAW kill of a queued entry
        tab[11] = '{0,  0, 0,  0,      0, 0,  0,     1, 9,  1,  0,  0,  0,      'h200};
        tab[12] = '{0,  0, 0,  0,      1, 9,  'hAA,  0, 0,  1,  0,  0,  0,      'h200};
        tab[13] = '{0,  1, 9,  'hBB,   0, 0,  0,     0, 0,  1,  1,  9,  'hBB,   0};
        tab[14] = '{0,  0, 0,  0,      0, 0,  0,     0, 0,  1,  0,  0,  0,      0};
        tab[15] = '{0,  0, 0,  0,      0, 0,  0,     0, 0,  1,  0,  0,  0,      0};
        // x0 traffic
        tab[16] = '{0,  1, 0,  'h5,    1, 0,  'h6,   1, 0,  1,  0,  0,  0,      0};
        tab[17] = '{0,  1, 0,  'h7,    0, 0,  0,     0, 0,  1,  0,  0,  0,      0};
        // scoreboard set/clear race
        tab[18] = '{0,  0, 0,  0,      1, 3,  'h33,  1, 3,  1,  0,  0,  0,      'h8};
        tab[19] = '{0,  0, 0,  0,      0, 0,  0,     1, 3,  1,  1,  3,  'h33,   'h8};
        tab[20] = '{0,  0, 0,  0,      0, 0,  0,     0, 0,  1,  0,  0,  0,      'h8};
        // reset with two entries queued
        tab[21] = '{0,  1, 4,  'h44,   1, 20, 'h14,  1, 20, 1,  1,  4,  'h44,   'h00100008};
        tab[22] = '{0,  1, 6,  'h66,   1, 21, 'h15,  0, 0,  1,  1,  6,  'h66,   'h00100008};
        tab[23] = '{1,  0, 0,  0,      0, 0,  0,     0, 0,  0,  0,  0,  0,      0};
        tab[24] = '{0,  0, 0,  0,      0, 0,  0,     0, 0,  1,  0,  0,  0,      0};
        tab[25] = '{0,  0, 0,  0,      0, 0,  0,     0, 0,  1,  0,  0,  0,      0};

        rst = 1'b1; a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        m_busy = '0; m_wen = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_cycle(tab[i], 1'b1, i);
        end

        for (int i = 0; i < 600; i++) begin
            v.rst    = (i == 0 || $urandom_range(0, 63) == 0) ? 1 : 0;
            v.av     = ($urandom_range(0, 2) == 0) ? 1 : 0;
            v.ard    = int'($urandom_range(0, 7));
            v.ad     = int'($urandom);
            v.bv     = ($urandom_range(0, 1) == 0) ? 1 : 0;
            v.brd    = int'($urandom_range(0, 7));
            v.bd     = int'($urandom);
            v.iv     = ($urandom_range(0, 3) == 0) ? 1 : 0;
            v.ird    = int'($urandom_range(0, 7));
            v.e_rdy  = 0; v.e_wen = 0; v.e_addr = 0; v.e_data = 0; v.e_busy = 0;
            run_cycle(v, 1'b0, i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
